// File: rtl/stage_memory_bus.sv
// Pipeline memory stage: request/response data-bus master with
// load alignment/extension, store lane placement and bus timeout.
module stage_memory_bus #(
    parameter int XLEN            = 32,
    parameter int REGID_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int TRAP_MISALIGNED = 1
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic                   i_Valid,
    input  logic                   i_MemRead,
    input  logic                   i_MemWrite,
    input  logic [2:0]             i_MemMode,
    input  logic                   i_RegWrite,
    input  logic [REGID_WIDTH-1:0] i_rd,
    input  logic [XLEN-1:0]        i_AluOutput,
    input  logic [XLEN-1:0]        i_rs2Value,
    output logic                   o_Stall,
    output logic                   o_BusReq,
    output logic                   o_BusWe,
    output logic [XLEN-1:0]        o_BusAddr,
    output logic [XLEN-1:0]        o_BusWData,
    output logic [XLEN/8-1:0]      o_BusByteEn,
    input  logic                   i_BusReady,
    input  logic                   i_BusRspValid,
    input  logic [XLEN-1:0]        i_BusRData,
    output logic                   o_Valid,
    output logic                   o_RegWrite,
    output logic [REGID_WIDTH-1:0] o_rd,
    output logic [XLEN-1:0]        o_AluOutput,
    output logic [XLEN-1:0]        o_MemoryValue,
    output logic                   o_MisalignedAccess,
    output logic                   o_BusError
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [LB-1:0]   off;
    logic            mem_op;
    logic            misaligned;
    logic            trap;
    logic            issue;
    logic            bus_done;
    logic            timeout;
    logic            in_req;
    logic [NB-1:0]   be_base;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_val;

    always_comb begin
        off    = i_AluOutput[LB-1:0];
        mem_op = i_MemRead | i_MemWrite;
        misaligned = 1'b0;
        unique case (i_MemMode)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = i_AluOutput[0];
            3'b010:         misaligned = |i_AluOutput[1:0];
            3'b110:         misaligned = (XLEN == 32) || (|i_AluOutput[1:0]);
            3'b011:         misaligned = (XLEN == 32) || (|i_AluOutput[2:0]);
            default:        misaligned = 1'b1;
        endcase
        trap  = misaligned && (TRAP_MISALIGNED != 0);
        issue = (state == IDLE) && i_Valid && mem_op && !trap;
        bus_done = ((state == REQ) && i_BusReady && i_BusRspValid) ||
                   ((state == RSP) && i_BusRspValid);
        timeout  = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                   !bus_done && (cnt == TO_LAST);
        // Reset gating keeps the stall low while the FSM is held in reset
        o_Stall = i_Reset_n &&
                  (issue || ((state != IDLE) && !bus_done && !timeout));
    end

    always_comb begin
        be_base = '0;
        unique case (i_MemMode[1:0])
            2'b00:   be_base = NB'(1);
            2'b01:   be_base = NB'(3);
            2'b10:   be_base = NB'(15);
            default: be_base = NB'(8'hFF);
        endcase
        in_req      = (state == REQ);
        o_BusReq    = in_req;
        o_BusWe     = in_req && i_MemWrite;
        o_BusAddr   = in_req ? {i_AluOutput[XLEN-1:LB], LB'(0)} : '0;
        o_BusByteEn = in_req ? (be_base << off) : '0;
        o_BusWData  = in_req ? (i_rs2Value << {off, 3'b000}) : '0;
    end

    always_comb begin
        lane     = i_BusRData >> {off, 3'b000};
        load_val = lane;
        unique case (i_MemMode)
            3'b000:  load_val = XLEN'($signed(lane[7:0]));
            3'b001:  load_val = XLEN'($signed(lane[15:0]));
            3'b010:  load_val = XLEN'($signed(lane[31:0]));
            3'b100:  load_val = XLEN'(lane[7:0]);
            3'b101:  load_val = XLEN'(lane[15:0]);
            3'b110:  load_val = XLEN'(lane[31:0]);
            default: load_val = lane;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state              <= IDLE;
            cnt                <= '0;
            o_Valid            <= 1'b0;
            o_RegWrite         <= 1'b0;
            o_rd               <= '0;
            o_AluOutput        <= '0;
            o_MemoryValue      <= '0;
            o_MisalignedAccess <= 1'b0;
            o_BusError         <= 1'b0;
        end else begin
            o_Valid            <= 1'b0;
            o_RegWrite         <= 1'b0;
            o_MisalignedAccess <= 1'b0;
            o_BusError         <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (i_Valid && !mem_op) begin
                        o_Valid       <= 1'b1;
                        o_RegWrite    <= i_RegWrite;
                        o_rd          <= i_rd;
                        o_AluOutput   <= i_AluOutput;
                        o_MemoryValue <= '0;
                    end else if (i_Valid && trap) begin
                        o_Valid            <= 1'b1;
                        o_MisalignedAccess <= 1'b1;
                        o_rd               <= i_rd;
                        o_AluOutput        <= i_AluOutput;
                        o_MemoryValue      <= '0;
                    end else if (issue) begin
                        state <= REQ;
                    end
                end
                REQ, RSP: begin
                    if (bus_done) begin
                        state              <= IDLE;
                        cnt                <= '0;
                        o_Valid            <= 1'b1;
                        o_RegWrite         <= i_RegWrite && !i_MemWrite;
                        o_rd               <= i_rd;
                        o_AluOutput        <= i_AluOutput;
                        o_MemoryValue      <= i_MemWrite ? '0 : load_val;
                        o_MisalignedAccess <= misaligned;
                    end else if (timeout) begin
                        state              <= IDLE;
                        cnt                <= '0;
                        o_Valid            <= 1'b1;
                        o_BusError         <= 1'b1;
                        o_rd               <= i_rd;
                        o_AluOutput        <= i_AluOutput;
                        o_MemoryValue      <= '0;
                        o_MisalignedAccess <= misaligned;
                    end else if ((state == REQ) && i_BusReady) begin
                        state <= RSP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_memory_bus.sv
// Directed bench for stage_memory_bus (XLEN=32, TIMEOUT_CYCLES=4).
module tb_stage_memory_bus;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, mrd, mwr, rwe;
    logic [2:0]  mode;
    logic [4:0]  rd;
    logic [31:0] alu, rs2;
    logic        stall, breq, bwe;
    logic [31:0] baddr, bwdata;
    logic [3:0]  bbe;
    logic        bready, brsp;
    logic [31:0] brdata;
    logic        ovalid, orwe;
    logic [4:0]  ord;
    logic [31:0] oalu, omem;
    logic        omis, oberr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stage_memory_bus #(
        .XLEN(32), .REGID_WIDTH(5),
        .TIMEOUT_CYCLES(4), .TRAP_MISALIGNED(1)
    ) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Valid(valid), .i_MemRead(mrd), .i_MemWrite(mwr),
        .i_MemMode(mode), .i_RegWrite(rwe), .i_rd(rd),
        .i_AluOutput(alu), .i_rs2Value(rs2),
        .o_Stall(stall), .o_BusReq(breq), .o_BusWe(bwe),
        .o_BusAddr(baddr), .o_BusWData(bwdata), .o_BusByteEn(bbe),
        .i_BusReady(bready), .i_BusRspValid(brsp), .i_BusRData(brdata),
        .o_Valid(ovalid), .o_RegWrite(orwe), .o_rd(ord),
        .o_AluOutput(oalu), .o_MemoryValue(omem),
        .o_MisalignedAccess(omis), .o_BusError(oberr)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic r, input logic w, input logic [2:0] m,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] dst, input logic we);
        valid = 1'b1; mrd = r; mwr = w; mode = m;
        alu = a; rs2 = d; rd = dst; rwe = we;
    endtask

    task automatic idle_in();
        valid = 1'b0; mrd = 1'b0; mwr = 1'b0; rwe = 1'b0;
        bready = 1'b0; brsp = 1'b0;
    endtask

    initial begin
        idle_in();
        mode = 3'b000; rd = '0; alu = '0; rs2 = '0; brdata = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_valid", ovalid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_busreq", breq, 0);
        chk("rst_alu", oalu, 0);
        rst_n = 1'b1;

        cyc();
        op(0, 0, 3'b000, 32'h1234, 0, 5'd7, 1);
        #1 chk("pt_stall", stall, 0);
        cyc();
        idle_in();
        chk("pt_valid", ovalid, 1);
        chk("pt_alu", oalu, 32'h1234);
        chk("pt_rd", ord, 7);
        chk("pt_rwe", orwe, 1);
        #1 chk("pt_stall2", stall, 0);
        cyc();
        chk("pt_novalid", ovalid, 0);

        op(1, 0, 3'b000, 32'h1003, 0, 5'd5, 1);
        #1 chk("lb_stall_idle", stall, 1);
        chk("lb_noreq_idle", breq, 0);
        cyc();
        #1 chk("lb_req", breq, 1);
        chk("lb_be", bbe, 4'b1000);
        chk("lb_addr", baddr, 32'h1000);
        chk("lb_we", bwe, 0);
        chk("lb_stall_r1", stall, 1);
        chk("lb_hold_valid", ovalid, 0);
        cyc();
        bready = 1'b1;
        #1 chk("lb_stall_r2", stall, 1);
        cyc();
        bready = 1'b0;
        #1 chk("lb_rsp_noreq", breq, 0);
        chk("lb_stall_s1", stall, 1);
        cyc();
        brsp = 1'b1; brdata = 32'h80FF_0000;
        #1 chk("lb_stall_done", stall, 0);
        cyc();
        idle_in();
        chk("lb_valid", ovalid, 1);
        chk("lb_mem", omem, 32'hFFFF_FF80);
        chk("lb_rd", ord, 5);
        chk("lb_rwe", orwe, 1);
        chk("lb_mis", omis, 0);
        cyc();
        chk("lb_nodup", ovalid, 0);

        op(0, 1, 3'b001, 32'h2002, 32'hABCD, 5'd0, 0);
        cyc();
        bready = 1'b1; brsp = 1'b1;
        #1 chk("sh_we", bwe, 1);
        chk("sh_be", bbe, 4'b1100);
        chk("sh_wdata", bwdata[31:16], 16'hABCD);
        chk("sh_addr", baddr, 32'h2000);
        chk("sh_stall", stall, 0);
        cyc();
        idle_in();
        chk("sh_valid", ovalid, 1);
        chk("sh_rwe", orwe, 0);
        chk("sh_mem", omem, 0);

        op(1, 0, 3'b101, 32'h5002, 0, 5'd9, 1);
        cyc();
        bready = 1'b1; brsp = 1'b1; brdata = 32'h8001_0000;
        #1 chk("lhu_be", bbe, 4'b1100);
        cyc();
        idle_in();
        chk("lhu_mem", omem, 32'h0000_8001);
        chk("lhu_valid", ovalid, 1);

        op(1, 0, 3'b010, 32'h3001, 0, 5'd3, 1);
        #1 chk("mis_stall", stall, 0);
        chk("mis_noreq", breq, 0);
        cyc();
        idle_in();
        chk("mis_valid", ovalid, 1);
        chk("mis_flag", omis, 1);
        chk("mis_rwe", orwe, 0);
        #1 chk("mis_noreq2", breq, 0);

        op(1, 0, 3'b010, 32'h4000, 0, 5'd4, 1);
        cyc();
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("to_stall%0d", i), stall, 1);
            chk($sformatf("to_req%0d", i), breq, 1);
            cyc();
        end
        #1 chk("to_stall4", stall, 0);
        chk("to_req4", breq, 1);
        cyc();
        idle_in();
        chk("to_valid", ovalid, 1);
        chk("to_berr", oberr, 1);
        chk("to_rwe", orwe, 0);
        #1 chk("to_idle", breq, 0);
        chk("to_stall_rel", stall, 0);
        cyc();
        chk("to_berr_clr", oberr, 0);

        op(1, 0, 3'b010, 32'h6000, 0, 5'd6, 1);
        cyc();
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        #1 chk("rr_in_rsp", stall, 1);
        rst_n = 1'b0;
        idle_in();
        #1 chk("rr_valid", ovalid, 0);
        chk("rr_stall", stall, 0);
        chk("rr_req", breq, 0);
        chk("rr_alu", oalu, 0);
        chk("rr_mem", omem, 0);
        chk("rr_rd", ord, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        brsp = 1'b1; brdata = 32'hDEAD_BEEF;
        cyc();
        brsp = 1'b0;
        chk("rr_stray", ovalid, 0);
        chk("rr_stray_mem", omem, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/stage_memory_bus.md
Name: stage_memory_bus

Overview:
Next-generation pipeline memory stage. It replaces the fixed single-cycle data-cache access with a parametrised request/response data-bus master that stalls the pipeline while an access is outstanding. Its other jobs:
- generates store byte enables and store lane alignment
- aligns and sign-extends load data
- detects misaligned accesses
- times out on an unresponsive bus

It sits between the execute stage and writeback, and registers all writeback-bound fields.

Parameters:
XLEN, 32, datapath width in bits (32 or 64); byte lanes = XLEN/8
REGID_WIDTH, 5, destination register ID width
TIMEOUT_CYCLES, 255, cycles waiting on a bus handshake before abort; 0 disables the timeout
TRAP_MISALIGNED, 1, 1 = misaligned access is suppressed and flagged; 0 = access is issued (bus handles it), flag still raised

Ports:
i_Clock  input  1  clock
i_Reset_n  input  1  asynchronous active-low reset
i_Valid  input  1  instruction present from execute
i_MemRead  input  1  load
i_MemWrite  input  1  store
i_MemMode  input  3  funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only)
i_RegWrite  input  1  writeback enable
i_rd  input  REGID_WIDTH  destination register
i_AluOutput  input  XLEN  effective address / ALU result
i_rs2Value  input  XLEN  store data
o_Stall  output  1  hold upstream stages and hold inputs stable
o_BusReq  output  1  request valid
o_BusWe  output  1  1 = write
o_BusAddr  output  XLEN  lane-aligned address (low log2(XLEN/8) bits zero)
o_BusWData  output  XLEN  store data shifted to byte lane
o_BusByteEn  output  XLEN/8  byte enables
i_BusReady  input  1  request accepted this cycle
i_BusRspValid  input  1  response (read data or write ack) valid
i_BusRData  input  XLEN  read data, full lane
o_Valid  output  1  writeback slot valid
o_RegWrite  output  1  writeback enable (gated)
o_rd  output  REGID_WIDTH  registered i_rd
o_AluOutput  output  XLEN  registered i_AluOutput
o_MemoryValue  output  XLEN  aligned and extended load result
o_MisalignedAccess  output  1  registered misalignment flag
o_BusError  output  1  registered timeout flag

Behaviour:
- Reset (asynchronous, i_Reset_n low):
  - State goes to IDLE.
  - o_Valid, o_RegWrite, o_BusReq, o_Stall, o_MisalignedAccess and o_BusError go to 0.
  - All data outputs go to 0.
  - Reset mid-transaction abandons the access; a later i_BusRspValid in IDLE is ignored.
- Misalignment: H requires addr[0]=0; W/WU require addr[1:0]=0; D requires addr[2:0]=0. Illegal modes (011/110 when XLEN=32, and 111) are treated as misaligned.
- FSM states: IDLE, REQ, RSP.
- IDLE, i_Valid and no memory op: register the pipeline fields next cycle, o_MemoryValue=0. Single-cycle pass-through, no stall.
- IDLE, i_Valid and (load or store):
  - Misaligned with TRAP_MISALIGNED=1: no bus request; next cycle o_Valid=1, o_MisalignedAccess=1, o_RegWrite=0.
  - Otherwise: o_Stall=1 combinationally, go to REQ.
- REQ:
  - o_BusReq=1; address, byte enables and data are driven from the held inputs and are stable until i_BusReady.
  - Byte enables: B -> 1 lane, H -> 2, W -> 4, D -> 8, each shifted by the low address bits.
  - Store data is replicated/shifted into the enabled lanes.
  - On i_BusReady go to RSP. i_BusRspValid in the same cycle as i_BusReady is legal and completes directly.
- RSP: wait for i_BusRspValid.
  - Load: extract the lanes selected by the low address bits, then sign-extend (B/H/W) or zero-extend (BU/HU/WU).
  - Store: o_MemoryValue=0.
  - Completion: o_Stall drops combinationally in the completion cycle. The next cycle carries o_Valid=1 and the registered fields; the FSM returns to IDLE.
- Stall: o_Stall=1 in REQ and RSP except the completion cycle; also asserted in IDLE in the first cycle of an issuing access.
- o_Valid=0 whenever no instruction completes that cycle, so stalls do not duplicate writebacks.
- Timeout:
  - A counter increments each cycle in REQ or RSP and clears on every state transition.
  - At TIMEOUT_CYCLES, abort to IDLE. The completing slot has o_Valid=1, o_BusError=1, o_RegWrite=0.
- o_MisalignedAccess and o_BusError are per-slot flags, valid only with o_Valid=1.
- Latency: non-memory op 1 cycle; memory op 2 cycles + bus wait cycles.

Test Plan:
- Pass-through, no bus stalls:
  - Non-memory instr, AluOutput=0x1234, rd=7 -> next cycle o_Valid=1, o_AluOutput=0x1234, o_rd=7, o_Stall never 1.
- LB with sign extension:
  - Inputs: XLEN=32, addr 0x1003, bus returns 0x80FF_0000 (byte lane 3 = 0x80), i_BusReady and i_BusRspValid each after 2 cycles.
  - Expect: o_BusByteEn=4'b1000, o_BusAddr=0x1000, o_MemoryValue=0xFFFF_FF80, o_Stall high throughout.
- SH store lane placement:
  - Inputs: SH addr 0x2002, rs2=0xABCD.
  - Expect: o_BusWe=1, o_BusByteEn=4'b1100, o_BusWData[31:16]=0xABCD; on completion o_RegWrite=0.
- Misaligned LW:
  - Inputs: LW addr 0x3001, TRAP_MISALIGNED=1.
  - Expect: no o_BusReq; next cycle o_MisalignedAccess=1, o_RegWrite=0.
- Timeout:
  - Inputs: TIMEOUT_CYCLES=4, i_BusReady held 0.
  - Expect: abort after 4 REQ cycles, o_BusError=1, o_Stall released, FSM in IDLE.
- Reset mid-RSP:
  - Stimulus: assert i_Reset_n=0 while in RSP, release, then pulse a stray i_BusRspValid.
  - Expect: all outputs 0 during reset; after release, the stray i_BusRspValid produces no o_Valid.
